ad7476a_sample_averager: RTL
============================

// Module: ad7476a_sample_averager
// PURPOSE
//  Drives the ADC interface's request input at a fixed sample rate and consumes its 12-bit samples.
//  Block-averages every 2**LOG2_AVG samples and presents the mean on a valid/ready stream to the DSP/host side.
//  Sits between the AD7476A SPI interface and downstream logic; flags lost ticks and dropped results.
// PARAMETERS
//  CLK_FREQ_HZ     100000000  system clock frequency
//  SAMPLE_RATE_HZ  1000000    request rate; PERIOD = CLK_FREQ_HZ/SAMPLE_RATE_HZ, elaboration must fail if PERIOD < 64
//  LOG2_AVG        2          log2 of samples per average; range 0..8; 0 = pass-through
//  DATA_WIDTH      12         sample width
// PORTS
//  clk_i           in   1           system clock
//  rst_i           in   1           reset, asynchronous, active-high
//  enable_i        in   1           run sampling
//  clear_i         in   1           synchronous clear of the sticky flags
//  request_o       out  1           to ADC interface request_i
//  sample_i        in   DATA_WIDTH  from ADC interface data_o
//  sample_valid_i  in   1           from ADC interface data_valid_o (1-cycle strobe)
//  avg_o           out  DATA_WIDTH  averaged result
//  avg_valid_o     out  1           avg_o valid
//  avg_ready_i     in   1           downstream accepts avg_o when valid&ready
//  missed_o        out  1           sticky: a tick arrived while a request was still outstanding
//  overrun_o       out  1           sticky: a result was dropped because the output register was full
// BEHAVIOUR
//  Reset values: request_o=0, avg_o=0, avg_valid_o=0, missed_o=0, overrun_o=0, state=IDLE, acc=0, cnt=0, tick counter=0.
//  Tick counter: runs only while enable_i=1, cleared while 0. tick pulses for 1 cycle when count==PERIOD-1, then wraps to 0.
//   The first tick comes PERIOD cycles after enable_i rises.
//  FSM (3 states):
//   IDLE    -> ARMED when enable_i=1. acc and cnt are cleared while in IDLE.
//   ARMED   -> REQUEST on tick. If enable_i=0, go to IDLE.
//   REQUEST -> on sample_valid_i: go to ARMED if enable_i=1, else IDLE.
//              A tick while in REQUEST with no sample_valid_i that cycle sets missed_o; that tick is discarded.
//  request_o = (state==REQUEST) & ~sample_valid_i. It is combinational so it drops in the strobe cycle,
//   and the ADC interface cannot re-trigger from its strobe state.
//  Disable mid-conversion: an outstanding REQUEST is never aborted. The block waits for the sample, accumulates it,
//   then goes to IDLE, and the partial block is discarded.
//  sample_valid_i outside REQUEST is ignored.
//  Accumulator: ACC_W = DATA_WIDTH+LOG2_AVG bits, unsigned, cannot overflow; cnt has LOG2_AVG bits.
//   On each accepted sample: if cnt != 2**LOG2_AVG-1, then acc += sample_i and cnt++.
//   Otherwise: result = (acc+sample_i)>>LOG2_AVG (truncating), and acc and cnt clear in the same cycle.
//  Output register: it loads the result the cycle after the final sample, so latency from the final strobe to avg_valid_o is 1 cycle.
//   The load succeeds if avg_valid_o=0, or if avg_valid_o&avg_ready_i in that same cycle (back-to-back drain and refill).
//   Otherwise the new result is dropped, avg_o holds its old value, and overrun_o is set.
//   avg_valid_o clears on a handshake with no simultaneous load. avg_o is stable while avg_valid_o=1 and avg_ready_i=0.
//  Sticky flags: clear_i clears them. If clear_i and a setting event occur in the same cycle, the flag ends set (set wins).
//  rst_i asserted at any time, including mid-request: all state returns to reset values immediately.
//   request_o drops asynchronously with the state.
// STRUCTURE
//  Shared package/header ad7476a_pkg: FSM state encodings, PERIOD computation function, DATA_WIDTH default.
//  One sub-module: periodic_strobe #(PERIOD) with enable_i and tick_o, containing the tick counter and reset-to-zero on disable.
//  The top level holds the FSM, accumulator and output register. The existing timer module is not reused.
// TESTING (CLK 100 MHz, rate 1 MHz => PERIOD=100, LOG2_AVG=2, ADC model strobes 20 cycles after request)
//  1. Reset then enable=1 -> first request_o at cycle 100.
//     Samples 0x100,0x200,0x300,0x401 -> avg_o=0x280 with avg_valid_o 1 cycle after the 4th strobe.
//  2. Four samples of 0xFFF -> avg_o=0xFFF, no overflow. Four samples of 0x000 -> avg_o=0x000.
//  3. avg_ready_i held 0 across two completed blocks -> first avg_o is held, overrun_o=1.
//     clear_i -> overrun_o=0. Raising ready then gives one handshake and avg_valid_o=0.
//  4. ADC model delays its strobe 150 cycles -> missed_o=1, exactly one sample is accumulated for that request,
//     and request_o is low in the strobe cycle.
//  5. enable_i dropped during REQUEST after 2 samples -> request_o stays high until the strobe, then IDLE.
//     Re-enable with 4 new samples gives their mean, with no contribution from the earlier samples.
//  6. rst_i pulsed mid-REQUEST and with avg_valid_o=1 -> all outputs 0 at once. Operation resumes correctly after release.

Source files
------------

// File: rtl/ad7476a_pkg.sv
// Shared definitions for the AD7476A sample averager: FSM encoding, default width, sample-period helper.
package ad7476a_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_REQUEST = 2'd2
    } avg_state_e;

    localparam int DATA_WIDTH_DEF = 12;
    localparam int MIN_PERIOD     = 64;

    function automatic int calc_period(input int clk_freq_hz, input int sample_rate_hz);
        return clk_freq_hz / sample_rate_hz;
    endfunction

endpackage

// File: rtl/ad7476a_sample_averager_strobe.sv
// Free-running period counter: one-cycle tick every PERIOD cycles while enabled, held at zero otherwise.
module periodic_strobe #(
    parameter int PERIOD = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int              CW   = $clog2(PERIOD);
    localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = '0;
        if (enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/ad7476a_sample_averager.sv
// Paces AD7476A conversions, block-averages 2**LOG2_AVG samples and offers the mean on a valid/ready stream.
module ad7476a_sample_averager
    import ad7476a_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100000000,
    parameter int SAMPLE_RATE_HZ = 1000000,
    parameter int LOG2_AVG       = 2,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    output logic                  request_o,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  sample_valid_i,
    output logic [DATA_WIDTH-1:0] avg_o,
    output logic                  avg_valid_o,
    input  logic                  avg_ready_i,
    output logic                  missed_o,
    output logic                  overrun_o
);

    localparam int PERIOD = calc_period(CLK_FREQ_HZ, SAMPLE_RATE_HZ);
    localparam int ACC_W  = DATA_WIDTH + LOG2_AVG;
    localparam int CNT_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << LOG2_AVG) - 1);

    generate
        if (PERIOD < MIN_PERIOD) begin : g_bad_period
            $error("ad7476a_sample_averager: sample period below 64 clocks");
        end
        if (LOG2_AVG < 0 || LOG2_AVG > 8) begin : g_bad_log2
            $error("ad7476a_sample_averager: LOG2_AVG out of range 0..8");
        end
    endgenerate

    logic tick;

    periodic_strobe #(.PERIOD(PERIOD)) u_strobe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .tick_o   (tick)
    );

    avg_state_e            state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] avg_q, avg_d;
    logic                  avg_valid_q, avg_valid_d;
    logic                  missed_q, missed_d;
    logic                  overrun_q, overrun_d;
    logic                  accept;
    logic                  block_done;
    logic [ACC_W-1:0]      sum;
    logic [DATA_WIDTH-1:0] result;

    // The accumulator is sized so a full block of maximum samples cannot overflow.
    assign sum    = acc_q + ACC_W'(sample_i);
    assign result = DATA_WIDTH'(sum >> LOG2_AVG);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_d       = avg_q;
        avg_valid_d = avg_valid_q;
        missed_d    = missed_q & ~clear_i;
        overrun_d   = overrun_q & ~clear_i;
        accept      = 1'b0;
        block_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (enable_i) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable_i)  state_d = ST_IDLE;
                else if (tick)  state_d = ST_REQUEST;
            end
            ST_REQUEST: begin
                // A pending conversion always completes, even after disable.
                if (sample_valid_i) begin
                    accept  = 1'b1;
                    state_d = enable_i ? ST_ARMED : ST_IDLE;
                end else if (tick) begin
                    missed_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (cnt_q != CNT_MAX) begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                acc_d      = '0;
                cnt_d      = '0;
                block_done = 1'b1;
            end
        end

        if (avg_valid_q && avg_ready_i) avg_valid_d = 1'b0;

        if (block_done) begin
            if (!avg_valid_q || avg_ready_i) begin
                avg_d       = result;
                avg_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            missed_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            missed_q    <= missed_d;
            overrun_q   <= overrun_d;
        end
    end

    // Dropping in the strobe cycle keeps the ADC interface from re-triggering.
    assign request_o   = (state_q == ST_REQUEST) && !sample_valid_i;
    assign avg_o       = avg_q;
    assign avg_valid_o = avg_valid_q;
    assign missed_o    = missed_q;
    assign overrun_o   = overrun_q;

endmodule
